uart_tx_fifo: RTL and testbench

- Transmit-side byte buffer placed directly upstream of uart_tx.
- Host logic pushes bytes at clock rate. The block pops one byte at a time and launches it into uart_tx with a one-cycle tx_start pulse.
- It tracks the uart_tx busy handshake so it never issues a start while a frame is in flight.
- It also reports fill level and a sticky overflow flag.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 26 ++
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: the transmit-FIFO state encoding and the default data width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } tx_fifo_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage for the transmit FIFO: synchronous write, asynchronous read.
// Storage carries no reset; validity is tracked by the pointers in the parent.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer feeding uart_tx: queues host bytes and launches them one at a time.
// Optional synchronous flush port is enabled with `define UART_TX_FIFO_FLUSH_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    tx_fifo_state_e    state;
    tx_fifo_state_e    state_next;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic [DATA_W-1:0] rd_data;
    logic              flush_req;
    logic              push_ok;
    logic              pop;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Every decision below uses registered flags, so a push while full is
    // rejected even when a pop frees a slot on the same edge.
    assign push_ok = push & ~full & ~flush_req;
    assign pop     = (state == S_IDLE) & ~empty & ~tx_busy & ~flush_req;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (PW)
    ) u_mem (
        .clk     (clk),
        .we      (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (push_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
            if (push & full) overflow <= 1'b1;
            tx_start <= pop;
            if (pop) tx_data <= rd_data;
            // Flush clears the queue only; a launched frame runs to completion.
            if (flush_req) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                empty    <= 1'b1;
                full     <= 1'b0;
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (pop)      state_next = S_START;
            S_START:                   state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy)  state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_busy) state_next = S_IDLE;
            default:                   state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple uart_tx busy model.
// Exercises the flush port as well when built with UART_TX_FIFO_FLUSH_EN.
module tb_uart_tx_fifo;

    localparam int DEPTH    = 16;
    localparam int DATA_W   = 8;
    localparam int CW       = $clog2(DEPTH+1);
    localparam int BUSY_LEN = 16;

    logic              clk;
    logic              rst;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
`ifdef UART_TX_FIFO_FLUSH_EN
    logic              flush;
`endif

    logic              force_busy;
    logic              model_busy;
    logic [DATA_W-1:0] seen [$];
    int                compared;
    int                mismatched;

    assign tx_busy = force_busy | model_busy;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef UART_TX_FIFO_FLUSH_EN
        .flush     (flush),
`endif
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every launched byte.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) seen.push_back(tx_data);
        end
    end

    // uart_tx stand-in: busy rises two edges after tx_start is sampled.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                @(posedge clk);
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (BUSY_LEN) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic do_push, input logic [DATA_W-1:0] data);
        push      = do_push;
        push_data = data;
        @(posedge clk);
        #1 push = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic waitLaunches(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (seen.size() >= n) break;
            @(posedge clk);
        end
        #1 checkOutput(tag, seen.size(), n);
    endtask

    task automatic waitBusyHigh(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (model_busy) break;
            @(posedge clk);
        end
        #1 checkOutput(tag, model_busy, 1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        push       = 1'b0;
        push_data  = '0;
        force_busy = 1'b0;
`ifdef UART_TX_FIFO_FLUSH_EN
        flush      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_tx_data", tx_data, 0);
        rst = 1'b1;

        $display("[TB] idle with no pushes");
        repeat (100) @(posedge clk);
        #1;
        checkOutput("idle_launches", seen.size(), 0);
        checkOutput("idle_empty", empty, 1);
        checkOutput("idle_count", count, 0);

        $display("[TB] single byte launch latency");
        applyStimulus(1'b1, 8'hA5);
        checkOutput("single_empty_drop", empty, 0);
        checkOutput("single_count_1", count, 1);
        checkOutput("single_no_start_yet", tx_start, 0);
        @(posedge clk);
        #1;
        checkOutput("single_start", tx_start, 1);
        checkOutput("single_data", tx_data, 8'hA5);
        checkOutput("single_count_0", count, 0);
        @(posedge clk);
        #1;
        checkOutput("single_pulse_width", tx_start, 0);
        checkOutput("single_data_held", tx_data, 8'hA5);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("single_one_launch", seen.size(), 1);
        checkOutput("single_empty_end", empty, 1);

        $display("[TB] fill to full and overflow");
        seen.delete();
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i));
        checkOutput("fill_full", full, 1);
        checkOutput("fill_count", count, 16);
        checkOutput("fill_no_overflow", overflow, 0);
        applyStimulus(1'b1, 8'hFF);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_count", count, 16);
        force_busy = 1'b0;
        waitLaunches("drain_launches", DEPTH, 1000);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("drain_total", seen.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < seen.size(); i++)
            checkOutput($sformatf("drain_byte_%0d", i), seen[i], i);
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_overflow_sticky", overflow, 1);

        $display("[TB] push rejected while full during a pop");
        pulseReset();
        seen.delete();
        checkOutput("r2_overflow_clear", overflow, 0);
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, 8'(8'h20 + i));
        checkOutput("edge_count_15", count, 15);
        checkOutput("edge_not_full", full, 0);
        applyStimulus(1'b1, 8'h11);
        checkOutput("edge_count_16", count, 16);
        checkOutput("edge_full", full, 1);
        checkOutput("edge_no_overflow", overflow, 0);
        force_busy = 1'b0;
        applyStimulus(1'b1, 8'h99);
        checkOutput("edge_overflow", overflow, 1);
        checkOutput("edge_pop_count", count, 15);
        checkOutput("edge_start", tx_start, 1);
        checkOutput("edge_first_data", tx_data, 8'h20);
        waitLaunches("edge_drain", DEPTH, 1000);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("edge_total", seen.size(), DEPTH);
        if (seen.size() >= DEPTH) checkOutput("edge_last_byte", seen[DEPTH-1], 8'h11);

        $display("[TB] reset with a frame in flight");
        pulseReset();
        seen.delete();
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h40 + i));
        force_busy = 1'b0;
        waitLaunches("mid_first_launch", 1, 20);
        waitBusyHigh("mid_busy_rise", 10);
        checkOutput("mid_count_5", count, 5);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_empty", empty, 1);
        checkOutput("mid_rst_overflow", overflow, 0);
        checkOutput("mid_rst_tx_start", tx_start, 0);
        repeat (60) @(posedge clk);
        #1;
        checkOutput("mid_no_relaunch", seen.size(), 1);

`ifdef UART_TX_FIFO_FLUSH_EN
        $display("[TB] flush with a frame in flight");
        seen.delete();
        force_busy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, 8'(8'h60 + i));
        checkOutput("fl_overflow_set", overflow, 1);
        force_busy = 1'b0;
        waitLaunches("fl_first_launch", 1, 20);
        waitBusyHigh("fl_busy_rise", 10);
        flush = 1'b1;
        applyStimulus(1'b1, 8'hEE);
        flush = 1'b0;
        checkOutput("fl_count", count, 0);
        checkOutput("fl_empty", empty, 1);
        checkOutput("fl_full", full, 0);
        checkOutput("fl_overflow", overflow, 0);
        repeat (60) @(posedge clk);
        #1;
        checkOutput("fl_no_relaunch", seen.size(), 1);
        applyStimulus(1'b1, 8'h5A);
        waitLaunches("fl_resume", 2, 20);
        if (seen.size() >= 2) checkOutput("fl_resume_data", seen[1], 8'h5A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
